// File: rtl/knights_pkg.sv
// Shared constants and the top-level state type for the robot command link.
package knights_pkg;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    typedef enum logic [1:0] {
        IDLE,
        TX_HI,
        TX_LO,
        WAIT_RESP
    } comm_state_e;

endpackage

// File: rtl/remote_uart.sv
// 8N1 byte serializer and deserializer; BAUD_DIV clocks per bit.
module remote_uart #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       TX,
    input  logic       RX,
    output logic       rx_rdy,
    output logic [7:0] rx_data
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    logic             tx_busy_q, tx_busy_d;
    logic [9:0]       tx_shift_q, tx_shift_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]       tx_idx_q, tx_idx_d;

    logic             rx_ff1_q, rx_ff2_q, rx_prev_q;
    logic             rx_busy_q, rx_busy_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]       rx_idx_q, rx_idx_d;
    logic             rx_rdy_q, rx_rdy_d;

    // The shift register idles at all ones so TX reads straight from bit 0.
    always_comb begin
        tx_busy_d  = tx_busy_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        if (!tx_busy_q) begin
            if (trmt) begin
                tx_busy_d  = 1'b1;
                tx_shift_d = {1'b1, tx_data, 1'b0};
                tx_cnt_d   = '0;
                tx_idx_d   = '0;
            end
        end else if (tx_cnt_q != BAUD_LAST) begin
            tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end else begin
            tx_cnt_d = '0;
            if (tx_idx_q == 4'd9) begin
                tx_busy_d = 1'b0;
            end else begin
                tx_idx_d   = tx_idx_q + 4'd1;
                tx_shift_d = {1'b1, tx_shift_q[9:1]};
            end
        end
    end

    assign tx_done = tx_busy_q && (tx_cnt_q == BAUD_LAST) && (tx_idx_q == 4'd9);
    assign TX      = tx_shift_q[0];

    // Index 0 is the start-bit midpoint; a high sample there is a glitch and is dropped.
    always_comb begin
        rx_busy_d  = rx_busy_q;
        rx_shift_d = rx_shift_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_rdy_d   = 1'b0;
        if (!rx_busy_q) begin
            if (rx_prev_q && !rx_ff2_q) begin
                rx_busy_d = 1'b1;
                rx_cnt_d  = HALF_LAST;
                rx_idx_d  = '0;
            end
        end else if (rx_cnt_q != '0) begin
            rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end else begin
            rx_cnt_d = BAUD_LAST;
            rx_idx_d = rx_idx_q + 4'd1;
            if (rx_idx_q == 4'd0) begin
                if (rx_ff2_q) rx_busy_d = 1'b0;
            end else if (rx_idx_q == 4'd9) begin
                rx_busy_d = 1'b0;
                rx_rdy_d  = 1'b1;
            end else begin
                rx_shift_d = {rx_ff2_q, rx_shift_q[7:1]};
            end
        end
    end

    assign rx_rdy  = rx_rdy_q;
    assign rx_data = rx_shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy_q  <= 1'b0;
            tx_shift_q <= '1;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            rx_ff1_q   <= 1'b1;
            rx_ff2_q   <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_shift_q <= '0;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_rdy_q   <= 1'b0;
        end else begin
            tx_busy_q  <= tx_busy_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            rx_ff1_q   <= RX;
            rx_ff2_q   <= rx_ff1_q;
            rx_prev_q  <= rx_ff2_q;
            rx_busy_q  <= rx_busy_d;
            rx_shift_q <= rx_shift_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_rdy_q   <= rx_rdy_d;
        end
    end

endmodule

// File: rtl/remote_comm.sv
// Sends a 16-bit command as two UART bytes, then collects robot responses
// until a non-progress byte arrives or the response gap times out.
module remote_comm
    import knights_pkg::*;
#(
    parameter int          BAUD_DIV = 434,
    parameter logic [25:0] RESP_TMO = 26'd50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd_cmd,
    input  logic [15:0] cmd,
    input  logic        RX,
    output logic        TX,
    output logic        cmd_snt,
    output logic        resp_rdy,
    output logic [7:0]  resp,
    output logic        busy,
    output logic        tmo
);

    localparam logic [25:0] TMO_LAST = RESP_TMO - 26'd1;

    comm_state_e state_q;
    logic [15:0] cmd_q;
    logic [7:0]  tx_data_q;
    logic        trmt_q;
    logic        cmd_snt_q;
    logic        resp_rdy_q;
    logic [7:0]  resp_q;
    logic        tmo_q;
    logic [25:0] tmo_cnt_q, tmo_cnt_d;

    logic        tx_done;
    logic        rx_rdy;
    logic [7:0]  rx_data;

    remote_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt_q),
        .tx_data (tx_data_q),
        .tx_done (tx_done),
        .TX      (TX),
        .RX      (RX),
        .rx_rdy  (rx_rdy),
        .rx_data (rx_data)
    );

    // Counts clocks since the last response byte; parks at its terminal value.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == TX_LO && tx_done) begin
            tmo_cnt_d = '0;
        end else if (state_q == WAIT_RESP) begin
            if (rx_rdy)
                tmo_cnt_d = '0;
            else if (tmo_cnt_q != TMO_LAST)
                tmo_cnt_d = tmo_cnt_q + 26'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            tx_data_q  <= '0;
            trmt_q     <= 1'b0;
            cmd_snt_q  <= 1'b0;
            resp_rdy_q <= 1'b0;
            resp_q     <= '0;
            tmo_q      <= 1'b0;
        end else begin
            trmt_q     <= 1'b0;
            resp_rdy_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (snd_cmd) begin
                        cmd_q     <= cmd;
                        cmd_snt_q <= 1'b0;
                        tmo_q     <= 1'b0;
                        tx_data_q <= cmd[15:8];
                        trmt_q    <= 1'b1;
                        state_q   <= TX_HI;
                    end
                end
                TX_HI: begin
                    if (tx_done) begin
                        tx_data_q <= cmd_q[7:0];
                        trmt_q    <= 1'b1;
                        state_q   <= TX_LO;
                    end
                end
                TX_LO: begin
                    if (tx_done) begin
                        cmd_snt_q <= 1'b1;
                        state_q   <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    // A byte landing on the timeout clock takes priority.
                    if (rx_rdy) begin
                        resp_q     <= rx_data;
                        resp_rdy_q <= 1'b1;
                        if (rx_data != RESP_BUSY) state_q <= IDLE;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        tmo_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_snt  = cmd_snt_q;
    assign resp_rdy = resp_rdy_q;
    assign resp     = resp_q;
    assign tmo      = tmo_q;
    assign busy     = (state_q != IDLE);

endmodule
